// File: rtl/alu_pipe.sv
// Two-stage pipelined Beta ALU execute unit with valid/ready handshakes.
// Stage 1 registers operands; stage 2 registers the selected result and adder flags.
module alu_pipe #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [5:0]       in_alufn,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_z,
  output logic             out_v,
  output logic             out_n,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    GRP_ARITH = 2'b00,
    GRP_BOOL  = 2'b01,
    GRP_SHIFT = 2'b10,
    GRP_CMP   = 2'b11
  } grp_e;

  logic             s1_valid;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  logic [5:0]       s1_fn;
  logic [TAG_W-1:0] s1_tag;

  logic adv2;
  logic in_xfer;

  assign adv2     = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | adv2;
  assign in_xfer  = in_valid & in_ready;

  grp_e        grp;
  logic        do_sub;
  logic [31:0] b_op;
  logic [31:0] sum;
  logic        zero;
  logic        ovf;
  logic        neg;
  logic        lt;
  logic [4:0]  shamt;

  assign grp    = grp_e'(s1_fn[5:4]);
  // Only group 00 with ALUFN[0]=0 adds; every other op derives flags from A-B.
  assign do_sub = ~((grp == GRP_ARITH) & ~s1_fn[0]);
  assign b_op   = do_sub ? ~s1_b : s1_b;
  assign sum    = s1_a + b_op + {31'b0, do_sub};
  assign zero   = (sum == '0);
  assign neg    = sum[31];
  assign ovf    = (s1_a[31] == b_op[31]) & (sum[31] != s1_a[31]);
  assign lt     = neg ^ ovf;
  assign shamt  = s1_b[4:0];

  logic [31:0] y;
  logic        ill;

  always_comb begin
    y   = '0;
    ill = 1'b0;
    case (grp)
      GRP_ARITH: y = sum;
      GRP_BOOL: begin
        for (int unsigned i = 0; i < 32; i++) begin
          y[i] = s1_fn[{1'b0, s1_b[i], s1_a[i]}];
        end
      end
      GRP_SHIFT: begin
        case (s1_fn[1:0])
          2'b00:   y = s1_a << shamt;
          2'b01:   y = s1_a >> shamt;
          2'b11:   y = 32'($signed(s1_a) >>> shamt);
          default: ill = 1'b1;
        endcase
      end
      GRP_CMP: begin
        case (s1_fn[2:1])
          2'b01:   y = {31'b0, zero};
          2'b10:   y = {31'b0, lt};
          2'b11:   y = {31'b0, zero | lt};
          default: ill = 1'b1;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_fn       <= '0;
      s1_tag      <= '0;
      out_valid   <= 1'b0;
      out_y       <= '0;
      out_z       <= 1'b0;
      out_v       <= 1'b0;
      out_n       <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_fn    <= in_alufn;
        s1_tag   <= in_tag;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end

      if (adv2) begin
        out_valid   <= 1'b1;
        out_y       <= y;
        out_z       <= zero;
        out_v       <= ovf;
        out_n       <= neg;
        out_illegal <= ill;
        out_tag     <= s1_tag;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases, stall/stream and flush
// scenarios, and randomized traffic scored against a behavioural model.
module tb_alu_pipe;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [5:0]       in_alufn;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic             out_z;
  logic             out_v;
  logic             out_n;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  alu_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_alufn(in_alufn), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_z(out_z), .out_v(out_v), .out_n(out_n),
    .out_illegal(out_illegal), .out_tag(out_tag)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0]      y;
    logic             z, v, n, ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [5:0] fn, input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint full;
    longint r;
    logic [31:0] sum;
    int     sh = int'(b % 32);
    full  = (fn[5:4] == 2'b00 && !fn[0]) ? sa + sb : sa - sb;
    sum   = full[31:0];
    e.z   = (sum == 0);
    e.n   = sum[31];
    e.v   = (full != longint'($signed(sum)));
    e.y   = 0;
    e.ill = 0;
    e.tag = tag;
    case (fn[5:4])
      2'b00: e.y = sum;
      2'b01: for (int i = 0; i < 32; i++) e.y[i] = fn[2 * int'(b[i]) + int'(a[i])];
      2'b10: case (fn[1:0])
        2'b00: e.y = a << sh;
        2'b01: e.y = a >> sh;
        2'b11: begin r = sa >>> sh; e.y = r[31:0]; end
        default: e.ill = 1;
      endcase
      default: case (fn[2:1])
        2'b01: e.y = (a == b) ? 1 : 0;
        2'b10: e.y = (sa < sb) ? 1 : 0;
        2'b11: e.y = (sa <= sb) ? 1 : 0;
        default: e.ill = 1;
      endcase
    endcase
    return e;
  endfunction

  exp_t        exp_q[$];
  int unsigned xfer_ticks[$];
  int unsigned tick = 0;
  logic        hold = 1'b0;
  logic [63:0] snap;

  always @(posedge clk) tick <= tick + 1;

  // Scoreboard: transfers are evaluated at the negedge preceding the edge that performs them.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold)
        check("stall_hold", 64'({out_y, out_z, out_v, out_n, out_illegal, out_tag}), snap);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("y", out_y, e.y);
          check("flags_zvni", {out_z, out_v, out_n, out_illegal}, {e.z, e.v, e.n, e.ill});
          check("tag", out_tag, e.tag);
          xfer_ticks.push_back(tick);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_model(in_a, in_b, in_alufn, in_tag));
      hold = out_valid && !out_ready;
      snap = 64'({out_y, out_z, out_v, out_n, out_illegal, out_tag});
    end
  end

  logic [TAG_W-1:0] dtag = '0;

  task automatic op(input string nm, input logic [31:0] a, input logic [31:0] b,
                    input logic [5:0] fn, input logic [31:0] ey, input logic eill);
    logic [TAG_W-1:0] t;
    t = dtag;
    dtag = dtag + 1'b1;
    @(posedge clk); #1;
    in_valid = 1; in_a = a; in_b = b; in_alufn = fn; in_tag = t; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_y"}, out_y, ey);
    check({nm, "_illegal"}, out_illegal, eill);
    check({nm, "_tag"}, out_tag, t);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom % 4)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return $urandom % 8;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc;
    int cyc;
    logic saw_low;
    int unsigned resume_tick;
    int unsigned first_t;
    int unsigned last_t;
    int n_after;

    reset = 1; in_valid = 0; in_a = '0; in_b = '0; in_alufn = '0; in_tag = '0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_y", out_y, 0);
    check("rst_flags", {out_z, out_v, out_n, out_illegal}, 0);
    check("rst_tag", out_tag, 0);

    op("add", 32'd5, 32'd7, 6'b000000, 32'd12, 0);
    check("add_z", out_z, 0);
    op("sub_ovf", 32'h8000_0000, 32'd1, 6'b000001, 32'h7FFF_FFFF, 0);
    check("sub_ovf_v", out_v, 1);
    check("sub_ovf_n", out_n, 0);
    op("cmplt", 32'hFFFF_FFFF, 32'd1, 6'b110100, 32'd1, 0);
    op("cmple", 32'd3, 32'd3, 6'b110110, 32'd1, 0);
    op("cmpeq", 32'd3, 32'd4, 6'b110010, 32'd0, 0);
    op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 6'b011000, 32'hF000_F000, 0);
    op("or",  32'hF0F0_F0F0, 32'hFF00_FF00, 6'b011110, 32'hFFF0_FFF0, 0);
    op("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 6'b010110, 32'h0FF0_0FF0, 0);
    op("shl", 32'h8000_0010, 32'd4, 6'b100000, 32'h0000_0100, 0);
    op("shr", 32'h8000_0010, 32'd4, 6'b100001, 32'h0800_0001, 0);
    op("sra", 32'h8000_0010, 32'd4, 6'b100011, 32'hF800_0001, 0);
    op("shl36", 32'h8000_0010, 32'd36, 6'b100000, 32'h0000_0100, 0);
    op("shr36", 32'h8000_0010, 32'd36, 6'b100001, 32'h0800_0001, 0);
    op("sra36", 32'h8000_0010, 32'd36, 6'b100011, 32'hF800_0001, 0);
    op("sh_ill", 32'h8000_0010, 32'd4, 6'b100010, 32'd0, 1);
    op("cmp_ill", 32'd3, 32'd3, 6'b110000, 32'd0, 1);

    // Stream of 8 ADDs with a 5-cycle downstream stall.
    @(posedge clk); #1;
    xfer_ticks.delete();
    acc = 0; cyc = 0; saw_low = 0; resume_tick = 0;
    while (acc < 8 && cyc < 100) begin
      if (cyc != 0) begin @(posedge clk); #1; end
      in_valid = 1; in_a = acc; in_b = 32'd1000; in_alufn = 6'b000000; in_tag = TAG_W'(acc);
      out_ready = !(cyc >= 2 && cyc < 7);
      if (cyc == 7) resume_tick = tick;
      @(negedge clk);
      if (!in_ready) saw_low = 1;
      else acc++;
      cyc++;
    end
    check("stream_accepted", acc, 8);
    check("stream_inready_drop", saw_low, 1);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    check("stream_drain_left", exp_q.size(), 0);
    check("stream_count", xfer_ticks.size(), 8);
    n_after = 0; first_t = 0; last_t = 0;
    foreach (xfer_ticks[k]) begin
      if (xfer_ticks[k] >= resume_tick) begin
        if (n_after == 0) first_t = xfer_ticks[k];
        last_t = xfer_ticks[k];
        n_after++;
      end
    end
    check("stream_resume_first", first_t, resume_tick);
    check("stream_back_to_back", last_t - first_t, n_after - 1);

    // Flush with both stages full.
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; in_a = 32'd11; in_b = 32'd22; in_alufn = 6'b000000; in_tag = 5'd9;
    @(posedge clk); #1;
    in_a = 32'd33; in_tag = 5'd10;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; out_ready = 1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      check("flush_no_stale", out_valid, 0);
    end

    // Randomized traffic.
    repeat (400) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_a      = rnd_word();
      in_b      = rnd_word();
      in_alufn  = 6'($urandom);
      in_tag    = TAG_W'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    check("rand_drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Two-stage pipelined Beta ALU execute unit with valid/ready handshakes on input and output.
- Stage 1 registers the operands, ALUFN and tag; these registered values drive the per-bit boolean unit, adder, shifter and comparator.
- Stage 2 registers the selected result, flags and tag for writeback.
- Sits between the register-file read stage and the writeback/memory stage.

Parameters:
- TAG_W, 5, width of the opaque tag (destination register number) carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage 1 can accept this cycle.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- in_alufn  input  6  Beta ALU function code.
- in_tag  input  TAG_W  passthrough tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_y  output  32  result.
- out_z, out_v, out_n  output  1 each  adder zero, overflow and negative flags of the operation.
- out_illegal  output  1  ALUFN was not a defined code.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset is synchronous and active-high on clk. Clock port is clk, reset port is reset.
- Reset values: s1_valid=0 and out_valid=0. out_y, out_tag and all flags are 0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards both stages. No result emerges for operations in flight.
- Transfers:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
- Advance rules:
  - adv2 = s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | adv2. This path is combinational from out_ready; there is no skid buffer.
- Stage 1 loads on input transfer. Otherwise it clears s1_valid when adv2 fires, and holds when stalled.
- Stage 2 loads on adv2. Otherwise it clears out_valid on output transfer.
- All out_* signals are stable while out_valid=1 and out_ready=0.
- Latency: result appears 2 cycles after input transfer. Throughput is 1 per cycle when out_ready=1.
- Simultaneous input transfer, adv2 and output transfer in the same cycle are all legal, and the pipeline stays full.
- Data fields are don't-care when the matching valid=0. Tag is unchanged end-to-end.
- ALUFN decode uses ALUFN[5:4]:
  - 00 arithmetic: ALUFN[0]=0 gives ADD, =1 gives SUB (A-B). ALUFN[3:1] is ignored. Results wrap mod 2^32.
  - 01 boolean: bit i of y = ALUFN[{b[i],a[i]}] (2-bit index, b is the MSB). Examples: AND=011000, OR=011110, XOR=010110, "A"=011010.
  - 10 shift by B[4:0]:
    - ALUFN[1:0]=00 is SHL.
    - 01 is SHR (logical).
    - 11 is SRA.
    - 10 is illegal.
  - 11 compare, computed from A-B flags, result 0 or 1 in bit 0:
    - ALUFN[2:1]=01 is CMPEQ (Z).
    - 10 is CMPLT (N^V).
    - 11 is CMPLE (Z|(N^V)).
    - 00 is illegal.
- Flags come from the adder for every op: ADD when ALUFN[0]=0 in group 00, otherwise A-B.
  - Z = (sum==0).
  - N = sum[31].
  - V = signed overflow of the performed add/sub.
- Illegal code: out_y=0, out_illegal=1, flags still reported. Otherwise out_illegal=0.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, out_y=0. Issue ADD A=5,B=7 with out_ready=1 -> 2 cycles later out_valid=1, out_y=12, out_z=0, tag matches.
- SUB A=0x80000000,B=1 -> out_y=0x7FFFFFFF, out_v=1, out_n=0. CMPLT A=-1 (0xFFFFFFFF),B=1 -> out_y=1. CMPLE A=3,B=3 -> out_y=1. CMPEQ A=3,B=4 -> out_y=0.
- Boolean A=0xF0F0F0F0, B=0xFF00FF00:
  - AND (011000) -> 0xF000F000.
  - OR (011110) -> 0xFFF0FFF0.
  - XOR (010110) -> 0x0FF00FF0.
- Shifts with A=0x80000010, B=4: SHL -> 0x00000100, SHR -> 0x08000001, SRA -> 0xF8000001. B=36 (B[4:0]=4) gives the same results. ALUFN=100010 -> out_y=0, out_illegal=1.
- Back-to-back stream of 8 ADDs with tags 0..7 and out_ready held 0 for 5 cycles mid-stream:
  - in_ready drops once both stages are full.
  - out_* stay constant while stalled.
  - All 8 results appear in order, none lost or duplicated.
  - 1 result/cycle after out_ready returns to 1.
- Assert reset with both stages valid -> next cycle out_valid=0 and in_ready=1; no stale result appears afterward.
